mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the core's load/store port.
- Replaces the behavioural pmem DPI calls with a synthesizable, handshaked word-addressed RAM.
- Serves one outstanding request at a time.
- Runs a valid/ready request channel, a fixed access latency, and a valid/ready response channel with error signalling.

Parameters:
- DEPTH, 1024, number of 32-bit words in the backing store (power of two).
- BASE_ADDR, 32'h80000000, byte address mapped to word 0.
- LATENCY, 2, wait cycles between request acceptance and memory access (0..15).

Ports:
- clk  input  1  clock, all state on posedge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_addr  input  32  byte address.
- req_wen  input  1  1 = write, 0 = read.
- req_wdata  input  32  write data, lane-aligned.
- req_wmask  input  4  byte-lane enables for writes; bit i selects wdata[8i+7:8i].
- rsp_valid  output  1  response present.
- rsp_ready  input  1  initiator accepts response.
- rsp_rdata  output  32  full read word; 0 for writes.
- rsp_err  output  1  address out of range.

Behaviour:
- Clock is clk. Reset is rst: asynchronous assert, active-low, released synchronously by the integrator.
- Reset state and outputs:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
  - RAM contents are not reset.
- FSM states IDLE, BUSY, RESP:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture addr/wen/wdata/wmask, load counter=LATENCY, go BUSY.
  - BUSY: req_ready=0. Counter decrements each cycle. When counter==0, perform the access this cycle, register rdata and err, go RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_ready. On rsp_valid&&rsp_ready, go IDLE.
- Latency: a request accepted at edge N gives rsp_valid=1 from cycle N+LATENCY+1 onward. With rsp_ready held high the round trip is LATENCY+2 cycles and the next accept happens one cycle after the response handshake. There is no back-to-back overlap.
- Address decode:
  - in range iff BASE_ADDR <= addr < BASE_ADDR+4*DEPTH.
  - index = (addr-BASE_ADDR)[log2(DEPTH)+1:2].
  - addr[1:0] is ignored for indexing; lane selection comes only from wmask.
- Write: RAM byte lane i updates iff wmask[i]. wmask=0 commits nothing but still produces a response with rsp_err reflecting the range check.
- Read: returns the full aligned word. Byte extraction belongs to the core.
- Out of range: write dropped, rsp_rdata=0, rsp_err=1. In range: rsp_err=0.
- Read during write: impossible because only one request is outstanding. A read after a completed write returns the new data.
- Reset mid-operation:
  - An uncommitted write (still in BUSY) is discarded.
  - A write that already reached RESP stays in RAM.
  - The response is dropped and the FSM returns to IDLE.
- rsp_ready held low: the responder stalls in RESP indefinitely and req_ready stays 0.

Optional Feature:
- MEM_RESP_RAND_DELAY_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded 8'hA5 on reset, advances once per accepted request.
  - Its low 2 bits add 0..3 extra BUSY cycles to that request.
  - rsp_valid timing becomes N+LATENCY+extra+1.
- Not defined: latency is exactly LATENCY and no LFSR logic is instantiated.

Decomposition:
- Package mem_resp_pkg holds:
  - state enum {IDLE, BUSY, RESP};
  - the default BASE_ADDR constant;
  - the WMASK_W=4 constant;
  - LFSR seed and tap constants.
- One sub-module, mem_resp_lfsr (8-bit LFSR with advance enable and async active-low reset), instantiated only under MEM_RESP_RAND_DELAY_EN.

Test Plan (DEPTH=1024, LATENCY=2, macro off unless noted):
- Reset: hold rst=0 for 3 cycles, release → req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Full-word write/read: write 0x80000010 / 0xDEADBEEF / wmask 4'hF, then read 0x80000010 → rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid asserted exactly 3 cycles after each accept.
- Byte-lane write: write 0x80000012 / 0x00AB0000 / wmask 4'b0100, then read 0x80000010 → 0xDEABBEEF.
- Out of range:
  - write 0x7FFFFFFC → rsp_err=1;
  - read 0x80001000 → rsp_rdata=0, rsp_err=1;
  - in-range contents unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid, rsp_rdata and rsp_err stable, req_ready=0. Release → IDLE next cycle, req_ready=1.
- Reset mid-BUSY: write 0x80000020 / 0x12345678, assert rst one cycle after accept, then read 0x80000020 → prior value (0 after preload) returned, no stale rsp_valid. With MEM_RESP_RAND_DELAY_EN, 100 random requests: latency in 3..6 cycles and data integrity holds.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder load/store RAM slice.
package mem_resp_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h8000_0000;
    localparam int unsigned WMASK_W           = 4;

    // Fibonacci taps 8,6,5,4 expressed as a mask over lfsr[7:0]
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/mem_resp_lfsr.sv
// 8-bit Fibonacci LFSR that steps once per asserted adv; used for random extra latency.
module mem_resp_lfsr
    import mem_resp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    output logic [7:0] value
);

    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/mem_responder.sv
// Handshaked word-addressed RAM responder, one outstanding request at a time.
// Define MEM_RESP_RAND_DELAY_EN to add 0..3 pseudo-random extra wait cycles per request.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
    parameter int unsigned LATENCY   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [31:0]        req_addr,
    input  logic               req_wen,
    input  logic [31:0]        req_wdata,
    input  logic [WMASK_W-1:0] req_wmask,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 5;
    localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 wen_q, wen_d;
    logic [WMASK_W-1:0]   wmask_q, wmask_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     extra;

    logic [31:0]          mem [DEPTH];
    logic [31:0]          offset;
    logic                 in_range;
    logic [IDX_W-1:0]     idx;
    logic                 access;
    logic                 accept;

    // Offset compare avoids overflow when BASE_ADDR + SPAN wraps 32 bits
    assign offset   = addr_q - BASE_ADDR;
    assign in_range = (addr_q >= BASE_ADDR) && (offset < SPAN);
    assign idx      = offset[IDX_W+1:2];
    assign access   = (state_q == BUSY) && (cnt_q == '0);
    assign accept   = req_valid && (state_q == IDLE);

`ifdef MEM_RESP_RAND_DELAY_EN
    logic [7:0] lfsr_val;
    logic       unused_lfsr;

    mem_resp_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .adv   (accept),
        .value (lfsr_val)
    );

    assign extra       = {3'b000, lfsr_val[1:0]};
    assign unused_lfsr = ^lfsr_val[7:2];
`else
    assign extra = '0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen_d   = wen_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wen_d   = req_wen;
                    wmask_d = req_wmask;
                    cnt_d   = CNT_W'(LATENCY) + extra;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    err_d   = !in_range;
                    rdata_d = (!wen_q && in_range) ? mem[idx] : '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Backing store is deliberately not reset
    always_ff @(posedge clk) begin
        if (access && wen_q && in_range) begin
            for (int i = 0; i < WMASK_W; i++) begin
                if (wmask_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed + scoreboard bench for mem_responder (random-delay section under MEM_RESP_RAND_DELAY_EN).
module tb_mem_responder;

    localparam int unsigned LATENCY = 2;
    localparam int          TIMEOUT = 60;
`ifdef MEM_RESP_RAND_DELAY_EN
    localparam int EXTRA_MAX = 3;
`else
    localparam int EXTRA_MAX = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    mem_responder #(
        .DEPTH     (1024),
        .BASE_ADDR (32'h8000_0000),
        .LATENCY   (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wen   (req_wen),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Called #1 after a posedge with the DUT idle; returns #1 after the post-handshake edge.
    task automatic transact(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                            input logic [3:0] wmask, input logic [31:0] exp_rdata,
                            input logic exp_err, input int hold);
        exp_t e;
        int   waited;
        int   lat;
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        rsp_ready = (hold == 0);
        req_addr  = addr;
        req_wen   = wen;
        req_wdata = wdata;
        req_wmask = wmask;
        req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < TIMEOUT) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
        chk_range("rsp_latency", lat, LATENCY + 1, LATENCY + 1 + EXTRA_MAX);
        chk("req_ready_in_resp", 32'(req_ready), 32'd0);
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
                chk("stall_valid", 32'(rsp_valid), 32'd1);
                chk("stall_rdata", rsp_rdata, e.rdata);
                chk("stall_err", 32'(rsp_err), 32'(e.err));
                chk("stall_req_ready", 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("post_hs_valid", 32'(rsp_valid), 32'd0);
        chk("post_hs_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic saw_rsp;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wen   = 1'b0;
        req_wdata = '0;
        req_wmask = '0;
        rsp_ready = 1'b1;

        // Reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);

        // Full word write/read
        transact(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 0);
        transact(32'h8000_0010, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0);

        // Single byte lane, then read with unaligned low bits
        transact(32'h8000_0012, 1'b1, 32'h00AB_0000, 4'b0100, 32'h0, 1'b0, 0);
        transact(32'h8000_0010, 1'b0, 32'h0, 4'h0, 32'hDEAB_BEEF, 1'b0, 0);
        transact(32'h8000_0013, 1'b0, 32'h0, 4'h0, 32'hDEAB_BEEF, 1'b0, 0);

        // Zero mask commits nothing
        transact(32'h8000_0010, 1'b1, 32'h1111_1111, 4'h0, 32'h0, 1'b0, 0);

        // Out of range on both sides
        transact(32'h7FFF_FFFC, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 0);
        transact(32'h8000_1000, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 0);
        transact(32'h8000_1000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 0);
        transact(32'h8000_0010, 1'b0, 32'h0, 4'h0, 32'hDEAB_BEEF, 1'b0, 0);

        // Last word in range
        transact(32'h8000_0FFC, 1'b1, 32'hA5A5_5A5A, 4'hF, 32'h0, 1'b0, 0);
        transact(32'h8000_0FFC, 1'b0, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b0, 0);

        // Backpressure
        transact(32'h8000_0010, 1'b0, 32'h0, 4'h0, 32'hDEAB_BEEF, 1'b0, 5);

        // Reset during BUSY discards the write and any response
        transact(32'h8000_0020, 1'b1, 32'h0, 4'hF, 32'h0, 1'b0, 0);
        req_addr  = 32'h8000_0020;
        req_wen   = 1'b1;
        req_wdata = 32'h1234_5678;
        req_wmask = 4'hF;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        saw_rsp = 1'b0;
        repeat (LATENCY + EXTRA_MAX + 4) begin
            @(posedge clk); #1;
            saw_rsp = saw_rsp | rsp_valid;
        end
        chk("no_stale_rsp", 32'(saw_rsp), 32'd0);
        transact(32'h8000_0020, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 0);

`ifdef MEM_RESP_RAND_DELAY_EN
        begin
            logic [31:0] model [16];
            logic [31:0] d;
            logic [3:0]  m;
            int          k;
            for (int i = 0; i < 16; i++) begin
                model[i] = $urandom;
                transact(32'h8000_0100 + 32'(i * 4), 1'b1, model[i], 4'hF, 32'h0, 1'b0, 0);
            end
            for (int n = 0; n < 100; n++) begin
                k = $urandom_range(0, 15);
                d = $urandom;
                m = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1) begin
                    transact(32'h8000_0100 + 32'(k * 4), 1'b1, d, m, 32'h0, 1'b0, 0);
                    for (int b = 0; b < 4; b++) begin
                        if (m[b]) model[k][8*b +: 8] = d[8*b +: 8];
                    end
                end else begin
                    transact(32'h8000_0100 + 32'(k * 4), 1'b0, 32'h0, 4'h0, model[k], 1'b0, 0);
                end
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
